// File: rtl/irt_dep_tracker.sv
// -----------------------------------------------------------------------------
// irt_dep_tracker
//   Instruction/register dependency tracker. Allocates up to BS slots for
//   in-flight instructions and records each slot's source and destination
//   registers as bitmaps. When an instruction is inserted, its dependency row
//   is built against every older live slot:
//     RAW : new source matches an older destination
//     WAR : new destination matches an older source
//     WAW : new destination matches an older destination
//   The row is stored in the slot and also published on idt for one cycle.
//   Retiring a slot clears its column in every row. A slot is issue-ready
//   once it is live and its row is all zero.
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   ins_valid/ins_ready insert handshake; ready = at least one free slot
//   ins_slot            slot the next insert takes (lowest free index)
//   ins_rs/ins_rs_en    NSRC source registers (src k at [k*RW +: RW]) + enables
//   ins_rd/ins_rd_en    destination register + enable
//   ret_valid/ret_slot  retire request for one slot (ignored if not live)
//   idt/idt_valid       dependency row of the last accepted insert
//   slot_live           per-slot valid bits
//   slot_ready          per-slot live & no outstanding dependency
//   occupancy           number of live slots
// -----------------------------------------------------------------------------
module irt_dep_tracker #(
  parameter int REGNUM  = 32,
  parameter int BS      = 16,
  parameter int NSRC    = 2,
  parameter int ZERO_RO = 1,
  localparam int RW     = $clog2(REGNUM),
  localparam int SW     = $clog2(BS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [SW-1:0]        ins_slot,
  input  logic [NSRC*RW-1:0]   ins_rs,
  input  logic [NSRC-1:0]      ins_rs_en,
  input  logic [RW-1:0]        ins_rd,
  input  logic                 ins_rd_en,
  input  logic                 ret_valid,
  input  logic [SW-1:0]        ret_slot,
  output logic [BS-1:0]        idt,
  output logic                 idt_valid,
  output logic [BS-1:0]        slot_live,
  output logic [BS-1:0]        slot_ready,
  output logic [SW:0]          occupancy
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [BS-1:0]              live_q,  live_d;
  logic [BS-1:0][REGNUM-1:0]  rsmap_q, rsmap_d;
  logic [BS-1:0][REGNUM-1:0]  rdmap_q, rdmap_d;
  logic [BS-1:0][BS-1:0]      dep_q,   dep_d;
  logic [BS-1:0]              idt_q,   idt_d;
  logic                       idt_valid_q, idt_valid_d;
  logic [SW:0]                occ_q,   occ_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [SW-1:0]      free_slot;
  logic               ins_fire;
  logic               ret_fire;
  logic [REGNUM-1:0]  rs_new;
  logic [REGNUM-1:0]  rd_new;
  logic [BS-1:0]      new_row;

  // Lowest-index free slot: scanning downward lets the lowest hit win.
  always_comb begin
    free_slot = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (!live_q[i]) free_slot = SW'(i);
    end
  end

  assign ins_ready = ~&live_q;
  assign ins_slot  = free_slot;
  assign ins_fire  = ins_valid & ins_ready;
  assign ret_fire  = ret_valid & live_q[ret_slot];

  // One-hot register bitmaps of the incoming instruction.
  always_comb begin
    rs_new = '0;
    rd_new = '0;
    for (int k = 0; k < NSRC; k++) begin
      for (int r = 0; r < REGNUM; r++) begin
        if (ins_rs_en[k] && (ins_rs[k*RW +: RW] == RW'(r))) rs_new[r] = 1'b1;
      end
    end
    for (int r = 0; r < REGNUM; r++) begin
      if (ins_rd_en && (ins_rd == RW'(r))) rd_new[r] = 1'b1;
    end
    // A hard-wired zero register never carries a value, so it never orders
    // instructions.
    if (ZERO_RO != 0) begin
      rs_new[0] = 1'b0;
      rd_new[0] = 1'b0;
    end
  end

  // Dependency row of the incoming instruction. A slot retiring on this same
  // edge is treated as already gone, and the destination slot itself is
  // excluded so the self-bit is always clear.
  always_comb begin
    new_row = '0;
    for (int j = 0; j < BS; j++) begin
      if (live_q[j] &&
          !(ret_fire && (ret_slot == SW'(j))) &&
          (free_slot != SW'(j))) begin
        new_row[j] = |((rs_new & rdmap_q[j]) |
                       (rd_new & rsmap_q[j]) |
                       (rd_new & rdmap_q[j]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking (=) assignments and assign every
  // output a default first, so later statements refine earlier ones and no
  // latch can be inferred.
  always_comb begin
    live_d      = live_q;
    rsmap_d     = rsmap_q;
    rdmap_d     = rdmap_q;
    dep_d       = dep_q;
    idt_d       = idt_q;
    idt_valid_d = 1'b0;
    occ_d       = occ_q;

    // Retire first: the inserting slot is always a different (free) slot, so
    // the insert below never overwrites retire effects on the same slot.
    if (ret_fire) begin
      live_d[ret_slot]  = 1'b0;
      rsmap_d[ret_slot] = '0;
      rdmap_d[ret_slot] = '0;
      dep_d[ret_slot]   = '0;
      for (int i = 0; i < BS; i++) begin
        dep_d[i][ret_slot] = 1'b0;
      end
    end

    if (ins_fire) begin
      live_d[free_slot]  = 1'b1;
      rsmap_d[free_slot] = rs_new;
      rdmap_d[free_slot] = rd_new;
      dep_d[free_slot]   = new_row;
      idt_d              = new_row;
      idt_valid_d        = 1'b1;
    end

    case ({ins_fire, ret_fire})
      2'b10:   occ_d = occ_q + (SW+1)'(1);
      2'b01:   occ_d = occ_q - (SW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the register-map and dependency arrays are reset along with the
  // control state; a mid-operation reset must leave no stale dependency that
  // a later insert could match against.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q      <= '0;
      rsmap_q     <= '0;
      rdmap_q     <= '0;
      dep_q       <= '0;
      idt_q       <= '0;
      idt_valid_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      live_q      <= live_d;
      rsmap_q     <= rsmap_d;
      rdmap_q     <= rdmap_d;
      dep_q       <= dep_d;
      idt_q       <= idt_d;
      idt_valid_q <= idt_valid_d;
      occ_q       <= occ_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_ready = '0;
    for (int i = 0; i < BS; i++) begin
      slot_ready[i] = live_q[i] & ~|dep_q[i];
    end
  end

  assign slot_live = live_q;
  assign idt       = idt_q;
  assign idt_valid = idt_valid_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_irt_dep_tracker.sv
// -----------------------------------------------------------------------------
// tb_irt_dep_tracker
//   Directed vector table, hand-written full/wrap and async-reset sequences,
//   and random traffic, all checked against a register-number level model.
// -----------------------------------------------------------------------------
module tb_irt_dep_tracker;

  localparam int REGNUM = 32;
  localparam int BS     = 16;
  localparam int NSRC   = 2;
  localparam int RW     = 5;
  localparam int SW     = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                ins_valid;
  logic                ins_ready;
  logic [SW-1:0]       ins_slot;
  logic [NSRC*RW-1:0]  ins_rs;
  logic [NSRC-1:0]     ins_rs_en;
  logic [RW-1:0]       ins_rd;
  logic                ins_rd_en;
  logic                ret_valid;
  logic [SW-1:0]       ret_slot;
  logic [BS-1:0]       idt;
  logic                idt_valid;
  logic [BS-1:0]       slot_live;
  logic [BS-1:0]       slot_ready;
  logic [SW:0]         occupancy;

  always #5 clk = ~clk;

  irt_dep_tracker #(.REGNUM(REGNUM), .BS(BS), .NSRC(NSRC), .ZERO_RO(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_slot   (ins_slot),
    .ins_rs     (ins_rs),
    .ins_rs_en  (ins_rs_en),
    .ins_rd     (ins_rd),
    .ins_rd_en  (ins_rd_en),
    .ret_valid  (ret_valid),
    .ret_slot   (ret_slot),
    .idt        (idt),
    .idt_valid  (idt_valid),
    .slot_live  (slot_live),
    .slot_ready (slot_ready),
    .occupancy  (occupancy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: slots hold register numbers, dependencies are a bit grid
  // ---------------------------------------------------------------------------
  bit            m_live   [BS];
  int            m_src    [BS][NSRC];
  bit            m_src_en [BS][NSRC];
  int            m_dst    [BS];
  bit            m_dst_en [BS];
  bit            m_dep    [BS][BS];
  logic [BS-1:0] m_idt;
  bit            m_idtv;

  function automatic void m_reset();
    for (int i = 0; i < BS; i++) begin
      m_live[i] = 0; m_dst[i] = 0; m_dst_en[i] = 0;
      for (int k = 0; k < NSRC; k++) begin m_src[i][k] = 0; m_src_en[i][k] = 0; end
      for (int j = 0; j < BS; j++) m_dep[i][j] = 0;
    end
    m_idt  = '0;
    m_idtv = 0;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < BS; i++) n += int'(m_live[i]);
    return n;
  endfunction

  function automatic int m_first_free();
    for (int i = 0; i < BS; i++) if (!m_live[i]) return i;
    return 0;
  endfunction

  function automatic logic [BS-1:0] m_live_vec();
    logic [BS-1:0] v = '0;
    for (int i = 0; i < BS; i++) v[i] = m_live[i];
    return v;
  endfunction

  function automatic logic [BS-1:0] m_ready_vec();
    logic [BS-1:0] v = '0;
    for (int i = 0; i < BS; i++) begin
      bit any = 0;
      for (int j = 0; j < BS; j++) any |= m_dep[i][j];
      v[i] = m_live[i] && !any;
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // One clock cycle: drive, check pre-edge, clock, update model, check post-edge
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit iv, input int rs0, input int rs1, input bit [1:0] rsen,
                       input int rd, input bit rden, input bit rv, input int rslot);
    int            rsv[NSRC];
    bit            ready_e, ifire, rfire;
    int            s;
    logic [BS-1:0] row;
    rsv[0] = rs0;
    rsv[1] = rs1;

    ins_valid = iv;
    ins_rs    = {RW'(rs1), RW'(rs0)};
    ins_rs_en = rsen;
    ins_rd    = RW'(rd);
    ins_rd_en = rden;
    ret_valid = rv;
    ret_slot  = SW'(rslot);
    #1;

    ready_e = (m_count() < BS);
    check("ins_ready", 32'(ins_ready), 32'(ready_e));
    if (ready_e) check("ins_slot", 32'(ins_slot), 32'(m_first_free()));

    // Model step: decide fires from pre-edge state, then retire, then insert.
    s     = m_first_free();
    ifire = iv && ready_e;
    rfire = rv && m_live[rslot];
    row   = '0;
    if (ifire) begin
      for (int j = 0; j < BS; j++) begin
        bit d = 0;
        if (!m_live[j] || (rfire && j == rslot) || j == s) continue;
        for (int k = 0; k < NSRC; k++)
          if (rsen[k] && rsv[k] != 0 && m_dst_en[j] && m_dst[j] == rsv[k]) d = 1;
        if (rden && rd != 0) begin
          if (m_dst_en[j] && m_dst[j] == rd) d = 1;
          for (int k = 0; k < NSRC; k++)
            if (m_src_en[j][k] && m_src[j][k] == rd) d = 1;
        end
        row[j] = d;
      end
    end
    if (rfire) begin
      m_live[rslot] = 0;
      m_dst_en[rslot] = 0;
      for (int k = 0; k < NSRC; k++) m_src_en[rslot][k] = 0;
      for (int i = 0; i < BS; i++) begin m_dep[i][rslot] = 0; m_dep[rslot][i] = 0; end
    end
    m_idtv = ifire;
    if (ifire) begin
      m_live[s]   = 1;
      m_dst[s]    = rd;
      m_dst_en[s] = rden && rd != 0;
      for (int k = 0; k < NSRC; k++) begin
        m_src[s][k]    = rsv[k];
        m_src_en[s][k] = rsen[k] && rsv[k] != 0;
      end
      for (int j = 0; j < BS; j++) m_dep[s][j] = row[j];
      m_idt = row;
    end

    @(posedge clk);
    #1;
    ins_valid = 1'b0;
    ret_valid = 1'b0;

    check("idt_valid",  32'(idt_valid),  32'(m_idtv));
    check("idt",        32'(idt),        32'(m_idt));
    check("slot_live",  32'(slot_live),  32'(m_live_vec()));
    check("slot_ready", 32'(slot_ready), 32'(m_ready_vec()));
    check("occupancy",  32'(occupancy),  32'(m_count()));
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            iv;
    int            rs0, rs1;
    bit [1:0]      rsen;
    int            rd;
    bit            rden;
    bit            rv;
    int            rslot;
    logic [BS-1:0] e_idt;
    bit            e_idtv;
    logic [BS-1:0] e_live;
    logic [BS-1:0] e_rdy;
    int            e_occ;
  } vec_t;

  function automatic vec_t mk(bit iv, int rs0, int rs1, bit [1:0] rsen, int rd, bit rden,
                              bit rv, int rslot, logic [BS-1:0] e_idt, bit e_idtv,
                              logic [BS-1:0] e_live, logic [BS-1:0] e_rdy, int e_occ);
    vec_t v;
    v.iv = iv; v.rs0 = rs0; v.rs1 = rs1; v.rsen = rsen; v.rd = rd; v.rden = rden;
    v.rv = rv; v.rslot = rslot; v.e_idt = e_idt; v.e_idtv = e_idtv;
    v.e_live = e_live; v.e_rdy = e_rdy; v.e_occ = e_occ;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ins_valid = 1'b0; ins_rs = '0; ins_rs_en = '0; ins_rd = '0; ins_rd_en = 1'b0;
    ret_valid = 1'b0; ret_slot = '0;
    m_reset();

    // RAW chain
    tbl.push_back(mk(1, 0, 0, 2'b00, 5, 1, 0, 0, 16'h0000, 1, 16'h0001, 16'h0001, 1));
    tbl.push_back(mk(1, 5, 6, 2'b11, 0, 0, 0, 0, 16'h0001, 1, 16'h0003, 16'h0001, 2));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 16'h0001, 0, 16'h0002, 16'h0002, 1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 1, 16'h0001, 0, 16'h0000, 16'h0000, 0));
    // WAR + WAW, then retire clears column 0
    tbl.push_back(mk(1, 3, 0, 2'b01, 7, 1, 0, 0, 16'h0000, 1, 16'h0001, 16'h0001, 1));
    tbl.push_back(mk(1, 0, 0, 2'b00, 7, 1, 0, 0, 16'h0001, 1, 16'h0003, 16'h0001, 2));
    tbl.push_back(mk(1, 0, 0, 2'b00, 3, 1, 0, 0, 16'h0001, 1, 16'h0007, 16'h0001, 3));
    tbl.push_back(mk(1, 0, 0, 2'b00, 7, 1, 0, 0, 16'h0003, 1, 16'h000F, 16'h0001, 4));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 16'h0003, 0, 16'h000E, 16'h0006, 3));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 1, 16'h0003, 0, 16'h000C, 16'h000C, 2));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 2, 16'h0003, 0, 16'h0008, 16'h0008, 1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 3, 16'h0003, 0, 16'h0000, 16'h0000, 0));
    // Zero register never creates a dependency
    tbl.push_back(mk(1, 0, 0, 2'b00, 0, 1, 0, 0, 16'h0000, 1, 16'h0001, 16'h0001, 1));
    tbl.push_back(mk(1, 0, 0, 2'b11, 0, 0, 0, 0, 16'h0000, 1, 16'h0003, 16'h0003, 2));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 16'h0000, 0, 16'h0002, 16'h0002, 1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0));
    // Simultaneous retire of slot 2 (rd=9) and insert reading r9
    tbl.push_back(mk(1, 0, 0, 2'b00, 1, 1, 0, 0, 16'h0000, 1, 16'h0001, 16'h0001, 1));
    tbl.push_back(mk(1, 9, 0, 2'b01, 2, 1, 0, 0, 16'h0000, 1, 16'h0003, 16'h0003, 2));
    tbl.push_back(mk(1, 0, 0, 2'b00, 9, 1, 0, 0, 16'h0002, 1, 16'h0007, 16'h0003, 3));
    tbl.push_back(mk(1, 9, 0, 2'b01, 0, 0, 1, 2, 16'h0000, 1, 16'h000B, 16'h000B, 3));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 16'h0000, 0, 16'h000A, 16'h000A, 2));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 1, 16'h0000, 0, 16'h0008, 16'h0008, 1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 3, 16'h0000, 0, 16'h0000, 16'h0000, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_live",      32'(slot_live), 32'h0);
    check("rst_occ",       32'(occupancy), 32'h0);
    check("rst_ins_ready", 32'(ins_ready), 32'h1);
    check("rst_ins_slot",  32'(ins_slot),  32'h0);
    check("rst_idt",       32'(idt),       32'h0);
    check("rst_idt_valid", 32'(idt_valid), 32'h0);

    foreach (tbl[i]) begin
      cycle(tbl[i].iv, tbl[i].rs0, tbl[i].rs1, tbl[i].rsen, tbl[i].rd, tbl[i].rden,
            tbl[i].rv, tbl[i].rslot);
      check($sformatf("tbl%0d_idt", i),   32'(idt),        32'(tbl[i].e_idt));
      check($sformatf("tbl%0d_idtv", i),  32'(idt_valid),  32'(tbl[i].e_idtv));
      check($sformatf("tbl%0d_live", i),  32'(slot_live),  32'(tbl[i].e_live));
      check($sformatf("tbl%0d_ready", i), 32'(slot_ready), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_occ", i),   32'(occupancy),  32'(tbl[i].e_occ));
    end

    // Full / wrap
    for (int i = 0; i < BS; i++) cycle(1, 0, 0, 2'b00, 0, 0, 0, 0);
    check("full_ready", 32'(ins_ready), 32'h0);
    check("full_occ",   32'(occupancy), 32'(BS));
    cycle(1, 0, 0, 2'b00, 3, 1, 0, 0);
    check("drop_idtv", 32'(idt_valid), 32'h0);
    check("drop_occ",  32'(occupancy), 32'(BS));
    cycle(0, 0, 0, 2'b00, 0, 0, 1, 4);
    check("wrap_ready", 32'(ins_ready), 32'h1);
    check("wrap_slot",  32'(ins_slot),  32'h4);
    check("wrap_occ",   32'(occupancy), 32'(BS - 1));
    cycle(0, 0, 0, 2'b00, 0, 0, 1, 4);  // retire of a non-live slot: no change
    check("noop_occ",   32'(occupancy), 32'(BS - 1));
    for (int i = 0; i < BS; i++) cycle(0, 0, 0, 2'b00, 0, 0, 1, i);
    check("empty_occ", 32'(occupancy), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 99) < 60,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 45, int'($urandom_range(0, BS - 1)));
    end

    // Mid-operation asynchronous reset
    for (int i = 0; i < 4; i++) cycle(1, 1, 2, 2'b11, 3, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_live",  32'(slot_live), 32'h0);
    check("arst_occ",   32'(occupancy), 32'h0);
    check("arst_idt",   32'(idt),       32'h0);
    check("arst_idtv",  32'(idt_valid), 32'h0);
    check("arst_ready", 32'(ins_ready), 32'h1);
    check("arst_slot",  32'(ins_slot),  32'h0);
    m_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 3, 0, 2'b01, 1, 1, 0, 0);
    check("post_arst_idt", 32'(idt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
